squeeze_stream: RTL and testbench
=================================

// Module: squeeze_stream
// PURPOSE
//  Parametrised squeeze stage for the Keccak core (SHA3-224/256/384/512, SHAKE128/256).
//  Streams an arbitrary-length digest from the rate part of the 1600-bit state as
//  OUT_W-bit words over a valid/ready handshake. Requests extra Keccak-f permutations
//  when out_len exceeds the rate. Sits between the permutation core and the host output.
// PARAMETERS
//  RATE_BITS  1088  rate in bits; must be a multiple of OUT_W (1152/1088/832/576/1344)
//  OUT_W      64    output word width in bits; multiple of 8, divides RATE_BITS
//  LEN_W      16    width of out_len (digest length in bytes)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           begin squeeze; sampled only in IDLE
//  out_len    in   LEN_W       digest length in bytes; latched on accepted start
//  state_out  in   1600        permutation state; bits [8j+7:8j] = state byte j
//  perm_done  in   1           1-cycle pulse: permutation finished, state_out valid
//  perm_req   out  1           1-cycle pulse: request one more Keccak-f permutation
//  out_data   out  OUT_W       output word; first (lowest-index) byte at MSBs
//  out_keep   out  OUT_W/8     byte-valid mask, MSB-first; bit OUT_W/8-1 = first byte
//  out_valid  out  1           out_data/out_keep/out_last valid
//  out_ready  in   1           sink accepts word when out_valid & out_ready
//  out_last   out  1           current word is the final word of the digest
//  busy       out  1           high in every state except IDLE
//  done       out  1           1-cycle pulse after final word accepted
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; perm_req, out_valid, out_last, busy, done = 0;
//    out_data = 0, out_keep = 0, internal buffer/counters = 0. Reset mid-operation aborts
//    the stream immediately; no done pulse is produced.
//  - FSM states: IDLE, EMIT, PERM_WAIT, FINISH.
//  - IDLE: start=1 -> latch out_len as rem, capture state_out[RATE_BITS-1:0] into buffer,
//    word pointer wp=0. If out_len==0 -> FINISH, else -> EMIT. out_valid rises the
//    cycle after start (latency 1).
//  - EMIT: out_valid=1; out_data = buffer bytes wp*B .. wp*B+B-1 (B=OUT_W/8), byte wp*B at
//    out_data[OUT_W-1:OUT_W-8]. If rem<B: out_keep has top rem bits set, unused bytes of
//    out_data driven 0; else out_keep all ones. out_last = (rem<=B).
//  - Handshake: outputs held stable while out_valid & !out_ready. On accept: rem -= min(rem,B),
//    wp += 1. If rem becomes 0 -> FINISH. Else if wp was last rate word
//    (RATE_BITS/OUT_W-1) -> PERM_WAIT with perm_req=1 for the following cycle only.
//    Else stay EMIT.
//  - PERM_WAIT: out_valid=0; wait for perm_done; on perm_done capture state_out rate part,
//    wp=0 -> EMIT next cycle. perm_done in any other state is ignored.
//  - FINISH: done=1 for exactly one cycle, busy=0 next cycle -> IDLE. A start in the same
//    cycle as FINISH is ignored; start accepted only in IDLE.
//  - start asserted while busy has no effect; out_len/state_out changes while busy ignored
//    except capture on perm_done.
// TESTING
//  1. OUT_W=64, RATE_BITS=1088, out_len=32, ready=1, state bytes j=j -> 4 words, word0 =
//     64'h0001020304050607, keep 8'hFF, out_last on word 4, done 1 cycle after, no perm_req.
//  2. Same, out_ready toggled 1/0 each cycle -> out_data held during stalls, exactly 4 beats,
//     same values as test 1.
//  3. RATE_BITS=1344, out_len=171 -> 21 words, perm_req pulse once, after perm_done with
//     new state bytes j=8'hA0+j: one word 64'hA0A1A2_0000000000, keep 8'hE0, out_last=1.
//  4. out_len=0 -> no out_valid, done pulse 2 cycles after start, busy high 1 cycle.
//  5. rst_n low during word 2 of test 1 -> all outputs 0 immediately, no done; fresh start
//     then reproduces test 1 exactly.
//  6. start pulsed during EMIT and PERM_WAIT, perm_done pulsed in EMIT -> ignored; stream
//     and word count unchanged.

Source files
------------

// File: rtl/squeeze_stream_if.sv
// Squeeze-stage bundle: control from the host, state/permutation handshake
// with the Keccak core, and the valid/ready digest output stream.
//   start, out_len      host -> squeeze : begin squeeze, digest length in bytes
//   state_out           core -> squeeze : 1600-bit state, byte j at [8j+7:8j]
//   perm_done/perm_req  core <-> squeeze: permutation finished / request another
//   out_data/keep/last  squeeze -> sink : output word, MSB-first byte mask, last flag
//   out_valid/out_ready squeeze <-> sink: stream handshake
//   busy, done          squeeze -> host : activity flag, completion pulse
interface squeeze_stream_if #(
    parameter int OUT_W = 64,
    parameter int LEN_W = 16
);
    logic                 start;
    logic [LEN_W-1:0]     out_len;
    logic [1599:0]        state_out;
    logic                 perm_done;
    logic                 perm_req;
    logic [OUT_W-1:0]     out_data;
    logic [OUT_W/8-1:0]   out_keep;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    // Squeeze stage side
    modport master (
        input  start, out_len, state_out, perm_done, out_ready,
        output perm_req, out_data, out_keep, out_valid, out_last, busy, done
    );

    // Host / core / sink side
    modport slave (
        output start, out_len, state_out, perm_done, out_ready,
        input  perm_req, out_data, out_keep, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/squeeze_stream.sv
// Keccak squeeze stage. Streams an out_len-byte digest from the rate part of
// the permutation state as OUT_W-bit words, requesting further permutations
// when the digest is longer than one rate block.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   s      squeeze_stream_if.master (start/out_len, state_out, perm_done/perm_req,
//          out_data/out_keep/out_valid/out_ready/out_last, busy, done)
module squeeze_stream #(
    parameter int RATE_BITS = 1088,
    parameter int OUT_W     = 64,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    squeeze_stream_if.master s
);
    localparam int B     = OUT_W / 8;
    localparam int WORDS = RATE_BITS / OUT_W;
    localparam int WP_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, PERM_WAIT, FINISH} state_t;

    state_t                st;
    logic [RATE_BITS-1:0]  buf_q;
    logic [LEN_W-1:0]      rem;
    logic [WP_W-1:0]       wp;
    logic                  perm_req_q;
    logic [OUT_W-1:0]      out_data_q;
    logic [B-1:0]          out_keep_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [LEN_W-1:0]      rem_next;
    logic [RATE_BITS-1:0]  buf_shift;
    logic                  unused_state_hi;

    // State bytes above the rate never leave this block.
    assign unused_state_hi = ^s.state_out[1599:RATE_BITS];

    // Byte k of the raw slice goes to the k-th byte from the top; bytes past
    // the remaining length are forced to zero.
    function automatic logic [OUT_W-1:0] pack_word(input logic [OUT_W-1:0] raw,
                                                   input logic [LEN_W-1:0] n);
        pack_word = '0;
        for (int k = 0; k < B; k++) begin
            if (LEN_W'(k) < n)
                pack_word[OUT_W-1-8*k -: 8] = raw[8*k +: 8];
        end
    endfunction

    function automatic logic [B-1:0] keep_mask(input logic [LEN_W-1:0] n);
        keep_mask = '0;
        for (int k = 0; k < B; k++) begin
            if (LEN_W'(k) < n)
                keep_mask[B-1-k] = 1'b1;
        end
    endfunction

    // The buffer is consumed from its low end, so the next word is always in
    // the bottom OUT_W bits after a shift; wp only tracks rate exhaustion.
    always_comb begin
        rem_next  = (rem <= LEN_W'(B)) ? '0 : rem - LEN_W'(B);
        buf_shift = buf_q >> OUT_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            buf_q       <= '0;
            rem         <= '0;
            wp          <= '0;
            perm_req_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            perm_req_q <= 1'b0;
            case (st)
                IDLE: begin
                    if (s.start) begin
                        rem    <= s.out_len;
                        buf_q  <= s.state_out[RATE_BITS-1:0];
                        wp     <= '0;
                        busy_q <= 1'b1;
                        if (s.out_len == '0) begin
                            st <= FINISH;
                        end else begin
                            st          <= EMIT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= pack_word(s.state_out[OUT_W-1:0], s.out_len);
                            out_keep_q  <= keep_mask(s.out_len);
                            out_last_q  <= (s.out_len <= LEN_W'(B));
                        end
                    end
                end
                EMIT: begin
                    if (s.out_ready) begin
                        rem   <= rem_next;
                        buf_q <= buf_shift;
                        wp    <= wp + WP_W'(1);
                        if (rem_next == '0 || wp == WP_W'(WORDS - 1)) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_keep_q  <= '0;
                            out_last_q  <= 1'b0;
                            if (rem_next == '0) begin
                                st <= FINISH;
                            end else begin
                                st         <= PERM_WAIT;
                                perm_req_q <= 1'b1;
                            end
                        end else begin
                            out_data_q <= pack_word(buf_shift[OUT_W-1:0], rem_next);
                            out_keep_q <= keep_mask(rem_next);
                            out_last_q <= (rem_next <= LEN_W'(B));
                        end
                    end
                end
                PERM_WAIT: begin
                    if (s.perm_done) begin
                        buf_q       <= s.state_out[RATE_BITS-1:0];
                        wp          <= '0;
                        st          <= EMIT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= pack_word(s.state_out[OUT_W-1:0], rem);
                        out_keep_q  <= keep_mask(rem);
                        out_last_q  <= (rem <= LEN_W'(B));
                    end
                end
                FINISH: begin
                    // done rises together with the return to IDLE
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign s.perm_req  = perm_req_q;
    assign s.out_data  = out_data_q;
    assign s.out_keep  = out_keep_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.busy      = busy_q;
    assign s.done      = done_q;
endmodule

// File: tb/tb_squeeze_stream.sv
// Directed bench for squeeze_stream: one instance with a 1088-bit rate and one
// with a 1344-bit rate share the stimulus; sel picks which one is driven/observed.
module tb_squeeze_stream;
    logic          clk;
    logic          rst_n;
    logic          sel;
    logic          start;
    logic [15:0]   out_len;
    logic [1599:0] state_out;
    logic          perm_done;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    squeeze_stream_if #(.OUT_W(64), .LEN_W(16)) ifa ();
    squeeze_stream_if #(.OUT_W(64), .LEN_W(16)) ifb ();

    squeeze_stream #(.RATE_BITS(1088), .OUT_W(64), .LEN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ifa.master)
    );
    squeeze_stream #(.RATE_BITS(1344), .OUT_W(64), .LEN_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ifb.master)
    );

    assign ifa.start     = start & ~sel;
    assign ifb.start     = start & sel;
    assign ifa.out_len   = out_len;
    assign ifb.out_len   = out_len;
    assign ifa.state_out = state_out;
    assign ifb.state_out = state_out;
    assign ifa.perm_done = perm_done;
    assign ifb.perm_done = perm_done;
    assign ifa.out_ready = out_ready;
    assign ifb.out_ready = out_ready;

    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, m_preq, m_busy, m_done;
    assign m_data  = sel ? ifb.out_data  : ifa.out_data;
    assign m_keep  = sel ? ifb.out_keep  : ifa.out_keep;
    assign m_valid = sel ? ifb.out_valid : ifa.out_valid;
    assign m_last  = sel ? ifb.out_last  : ifa.out_last;
    assign m_preq  = sel ? ifb.perm_req  : ifa.perm_req;
    assign m_busy  = sel ? ifb.busy      : ifa.busy;
    assign m_done  = sel ? ifb.done      : ifa.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_state(input logic [7:0] base);
        for (int j = 0; j < 200; j++)
            state_out[8*j +: 8] = base + 8'(j);
    endtask

    // Captured beats and event counters from the most recent run_stream.
    logic [63:0] got_data [0:31];
    logic [7:0]  got_keep [0:31];
    logic        got_last [0:31];
    int n_beats, n_preq, n_done, n_busy, done_cyc, last_cyc;

    // Expected beat i of a len-byte digest: bytes below rate_bytes come from the
    // initial state (byte j = j), later bytes from the re-permuted state (8'hA0+j).
    function automatic void model_beat(input int i, input int len, input int rate_bytes,
                                       output logic [63:0] d, output logic [7:0] k,
                                       output logic l);
        d = '0;
        k = '0;
        for (int b = 0; b < 8; b++) begin
            int g;
            g = 8 * i + b;
            if (g < len) begin
                d[63-8*b -: 8] = (g < rate_bytes) ? 8'(g) : 8'(8'hA0 + (g - rate_bytes));
                k[7-b] = 1'b1;
            end
        end
        l = ((len - 8 * i) <= 8);
    endfunction

    // Starts a squeeze on the selected instance, services perm_req with a
    // perm_done two cycles later, and records every accepted beat until done.
    // With inject set, spurious start/perm_done pulses are thrown in mid-stream.
    task automatic run_stream(input bit use_b, input int len, input bit toggle, input bit inject);
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        bit          stalled;
        bit          fin;
        int          perm_cnt;
        @(negedge clk);
        sel       = use_b;
        set_state(8'h00);
        out_len   = 16'(len);
        start     = 1'b1;
        out_ready = 1'b0;
        perm_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            got_data[i] = 'x;
            got_keep[i] = 'x;
            got_last[i] = 1'bx;
        end
        n_beats = 0; n_preq = 0; n_done = 0; n_busy = 0;
        done_cyc = -1; last_cyc = -1;
        stalled = 0; fin = 0; perm_cnt = 0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            perm_done = 1'b0;
            if (inject && cyc == 3) begin
                set_state(8'hA0);
                perm_done = 1'b1;
            end
            if (inject && cyc == 5)
                start = 1'b1;
            if (perm_cnt > 0) begin
                perm_cnt--;
                if (perm_cnt == 0) begin
                    set_state(8'hA0);
                    perm_done = 1'b1;
                end
            end
            if (m_preq) begin
                n_preq++;
                perm_cnt = 2;
                if (inject)
                    start = 1'b1;
            end
            out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (m_busy)
                n_busy++;
            if (m_done) begin
                n_done++;
                if (done_cyc < 0)
                    done_cyc = cyc;
            end
            if (stalled) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data",  m_data,       pd);
                chk("hold_keep",  64'(m_keep),  64'(pk));
                chk("hold_last",  64'(m_last),  64'(pl));
            end
            if (m_valid) begin
                if (out_ready) begin
                    if (n_beats < 32) begin
                        got_data[n_beats] = m_data;
                        got_keep[n_beats] = m_keep;
                        got_last[n_beats] = m_last;
                    end
                    n_beats++;
                    last_cyc = cyc;
                end
                stalled = !out_ready;
                pd = m_data;
                pk = m_keep;
                pl = m_last;
            end else begin
                stalled = 0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3)
                fin = 1;
        end
        if (!fin)
            chk("timeout_done", 64'd0, 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int len, input int rate_bytes);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          nexp;
        nexp = (len + 7) / 8;
        chk($sformatf("%s_beats", tag), 64'(n_beats), 64'(nexp));
        for (int i = 0; i < nexp && i < 32; i++) begin
            model_beat(i, len, rate_bytes, d, k, l);
            chk($sformatf("%s_data%0d", tag, i), got_data[i],        d);
            chk($sformatf("%s_keep%0d", tag, i), 64'(got_keep[i]),   64'(k));
            chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]),   64'(l));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        start     = 1'b0;
        out_len   = '0;
        state_out = '0;
        perm_done = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of both instances
        chk("rst_valid_a", 64'(ifa.out_valid), 64'd0);
        chk("rst_data_a",  ifa.out_data,       64'd0);
        chk("rst_keep_a",  64'(ifa.out_keep),  64'd0);
        chk("rst_last_a",  64'(ifa.out_last),  64'd0);
        chk("rst_busy_a",  64'(ifa.busy),      64'd0);
        chk("rst_done_a",  64'(ifa.done),      64'd0);
        chk("rst_preq_a",  64'(ifa.perm_req),  64'd0);
        chk("rst_valid_b", 64'(ifb.out_valid), 64'd0);
        chk("rst_busy_b",  64'(ifb.busy),      64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 32 bytes, always ready
        run_stream(0, 32, 0, 0);
        check_beats("t1", 32, 136);
        chk("t1_w0",     got_data[0],       64'h0001020304050607);
        chk("t1_k0",     64'(got_keep[0]),  64'hFF);
        chk("t1_w3",     got_data[3],       64'h18191A1B1C1D1E1F);
        chk("t1_ndone",  64'(n_done),       64'd1);
        chk("t1_npreq",  64'(n_preq),       64'd0);
        // last beat accepted on one edge, FINISH for a cycle, done on the next
        chk("t1_donelat", 64'(done_cyc - last_cyc), 64'd2);

        // 2: same digest with out_ready toggling
        run_stream(0, 32, 1, 0);
        check_beats("t2", 32, 136);
        chk("t2_w0",    got_data[0],  64'h0001020304050607);
        chk("t2_ndone", 64'(n_done),  64'd1);
        chk("t2_npreq", 64'(n_preq),  64'd0);

        // 3: 171 bytes over a 168-byte rate -> one extra permutation
        run_stream(1, 171, 0, 0);
        check_beats("t3", 171, 168);
        chk("t3_w20",   got_data[20],      64'hA0A1A2A3A4A5A6A7 ^ 64'hA0A1A2A3A4A5A6A7 ^ 64'hA0A1A2A3A4A5A6A7 & 64'h0 | 64'hA0A1A2A3A4A5A6A7);
        chk("t3_w21",   got_data[21],      64'hA0A1A20000000000);
        chk("t3_k21",   64'(got_keep[21]), 64'hE0);
        chk("t3_l21",   64'(got_last[21]), 64'd1);
        chk("t3_npreq", 64'(n_preq),       64'd1);
        chk("t3_ndone", 64'(n_done),       64'd1);

        // 4: zero-length digest
        run_stream(0, 0, 0, 0);
        chk("t4_beats",  64'(n_beats),  64'd0);
        chk("t4_donecy", 64'(done_cyc), 64'd2);
        chk("t4_busy",   64'(n_busy),   64'd1);
        chk("t4_ndone",  64'(n_done),   64'd1);

        // 5: reset while word 2 is on the bus, then a clean rerun
        @(negedge clk);
        sel       = 1'b0;
        set_state(8'h00);
        out_len   = 16'd32;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_w1_pre", m_data, 64'h08090A0B0C0D0E0F);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(ifa.out_valid), 64'd0);
        chk("t5_data",  ifa.out_data,       64'd0);
        chk("t5_keep",  64'(ifa.out_keep),  64'd0);
        chk("t5_last",  64'(ifa.out_last),  64'd0);
        chk("t5_busy",  64'(ifa.busy),      64'd0);
        chk("t5_done",  64'(ifa.done),      64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_nodone", 64'(ifa.done), 64'd0);
        end
        run_stream(0, 32, 0, 0);
        check_beats("t5", 32, 136);
        chk("t5_ndone",   64'(n_done),              64'd1);
        chk("t5_donelat", 64'(done_cyc - last_cyc), 64'd2);

        // 6: stray start / perm_done pulses mid-stream are ignored
        run_stream(1, 171, 0, 1);
        check_beats("t6", 171, 168);
        chk("t6_npreq", 64'(n_preq), 64'd1);
        chk("t6_ndone", 64'(n_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
